// File: rtl/fetch_pc_sched.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_sched
// Purpose  : Per-warp PC file and round-robin fetch scheduler for the IF stage.
//            Optional fetch counter output enabled by FETCH_PERF_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module fetch_pc_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        Update_TM_IF,
    input  logic [2:0]  WarpID_TM_IF,
    input  logic [9:0]  StartPC_TM_IF,
    input  logic [7:0]  UpdatePC_Qual1_SIMT_IF,
    input  logic [7:0]  UpdatePC_Qual2_SIMT_IF,
    input  logic [79:0] TA_SIMT_IF_Flattened,
    input  logic [7:0]  UpdatePC_Qual3_ID_IF,
    input  logic [9:0]  TA_ID_IF,
    input  logic [7:0]  Stall_SIMT_IF,
    input  logic [7:0]  Full_IB_IF,
    input  logic [7:0]  Exit_ID_IF,
    output logic [9:0]  PC_IF_ICache,
    output logic [2:0]  WarpID_IF_ICache,
    output logic        Valid_IF_ICache,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0] FetchCnt_IF,
`endif
    output logic [7:0]  Active_IF
);

    localparam int         c_NWARP = 8;
    localparam logic [9:0] c_PC_STEP = 10'd4;

    logic [9:0] r_pc [c_NWARP];
    logic [7:0] r_active;
    logic [2:0] r_last;
    logic [9:0] r_fetch_pc;
    logic [2:0] r_fetch_wid;
    logic       r_fetch_vld;

    logic [9:0] w_ta_simt [c_NWARP];
    logic [7:0] w_start;
    logic [7:0] w_redirect;
    logic [7:0] w_elig;
    logic [7:0] w_grant_oh;
    logic       w_grant_vld;
    logic [2:0] w_grant_id;
    logic [2:0] w_cand;

    genvar g;
    generate
        for (g = 0; g < c_NWARP; g++) begin : g_warp
            assign w_ta_simt[g] = TA_SIMT_IF_Flattened[10*g +: 10];
            assign w_start[g]   = Update_TM_IF && (WarpID_TM_IF == 3'(g));
        end
    endgenerate

    assign w_redirect = UpdatePC_Qual1_SIMT_IF | UpdatePC_Qual2_SIMT_IF | UpdatePC_Qual3_ID_IF;
    assign w_elig     = r_active & ~Stall_SIMT_IF & ~Full_IB_IF & ~w_redirect
                      & ~Exit_ID_IF & ~w_start;

    // Scan backwards from Last+8 down to Last+1 so the closest candidate wins.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = 3'd0;
        w_cand      = 3'd0;
        for (int i = c_NWARP; i >= 1; i--) begin
            w_cand = r_last + 3'(i);
            if (w_elig[w_cand]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = w_cand;
            end
        end
    end

    always_comb begin
        w_grant_oh = 8'h00;
        if (w_grant_vld) begin
            w_grant_oh[w_grant_id] = 1'b1;
        end
    end

    // Start dominates both redirects and Exit for the same warp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < c_NWARP; w++) begin
                r_pc[w] <= 10'd0;
            end
            r_active <= 8'h00;
        end else begin
            for (int w = 0; w < c_NWARP; w++) begin
                if (w_start[w]) begin
                    r_pc[w]     <= StartPC_TM_IF;
                    r_active[w] <= 1'b1;
                end else begin
                    if (UpdatePC_Qual1_SIMT_IF[w] || UpdatePC_Qual2_SIMT_IF[w]) begin
                        r_pc[w] <= w_ta_simt[w];
                    end else if (UpdatePC_Qual3_ID_IF[w]) begin
                        r_pc[w] <= TA_ID_IF;
                    end else if (w_grant_oh[w]) begin
                        r_pc[w] <= r_pc[w] + c_PC_STEP;
                    end
                    if (Exit_ID_IF[w]) begin
                        r_active[w] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last      <= 3'd7;
            r_fetch_pc  <= 10'd0;
            r_fetch_wid <= 3'd0;
            r_fetch_vld <= 1'b0;
        end else begin
            r_fetch_vld <= w_grant_vld;
            if (w_grant_vld) begin
                r_last      <= w_grant_id;
                r_fetch_pc  <= r_pc[w_grant_id];
                r_fetch_wid <= w_grant_id;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_fetch_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt <= 16'd0;
        end else if (w_grant_vld && (r_fetch_cnt != 16'hFFFF)) begin
            r_fetch_cnt <= r_fetch_cnt + 16'd1;
        end
    end

    assign FetchCnt_IF = r_fetch_cnt;
`endif

    assign PC_IF_ICache     = r_fetch_pc;
    assign WarpID_IF_ICache = r_fetch_wid;
    assign Valid_IF_ICache  = r_fetch_vld;
    assign Active_IF        = r_active;

endmodule
`default_nettype wire

// File: doc/fetch_pc_sched.md
# fetch_pc_sched

Per-warp program-counter file and fetch scheduler for the IF stage, the consumer of SIMT's per-warp redirect/stall outputs. It holds one 10-bit PC and an active bit per warp (8 warps) and applies redirects from SIMT (Qual1/Qual2 plus target address) and Decode (Qual3 plus target). Each cycle it grants one eligible warp round-robin and issues its PC to the instruction cache.

## Interface
- No parameters; warp count 8, PC width 10 (fixed by the SIMT interface).
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- Update_TM_IF  in  1  start a warp
- WarpID_TM_IF  in  3  warp being started
- StartPC_TM_IF  in  10  initial PC for that warp
- UpdatePC_Qual1_SIMT_IF  in  8  per-warp redirect to SIMT target (priority 1)
- UpdatePC_Qual2_SIMT_IF  in  8  per-warp redirect to SIMT target (priority 2)
- TA_SIMT_IF_Flattened  in  80  SIMT targets; warp w in bits [10w+9:10w]
- UpdatePC_Qual3_ID_IF  in  8  per-warp redirect from Decode (jmp/call)
- TA_ID_IF  in  10  Decode target, shared by all warps
- Stall_SIMT_IF  in  8  per-warp fetch stall from SIMT
- Full_IB_IF  in  8  per-warp IBuffer full
- Exit_ID_IF  in  8  per-warp EXIT decoded; deactivates the warp
- PC_IF_ICache  out  10  fetch address (registered)
- WarpID_IF_ICache  out  3  warp of the fetch (registered)
- Valid_IF_ICache  out  1  fetch valid (registered)
- Active_IF  out  8  current active-warp mask

## Operation
- State per warp w: PC[w] (10 b), Active[w]. RR pointer Last (3 b) = most recently granted warp.
- Next PC for warp w, highest priority first:
  1. Start (Update_TM_IF and WarpID_TM_IF==w): PC <= StartPC_TM_IF, Active <= 1.
  2. Qual1[w]: PC <= TA_SIMT[w].
  3. Qual2[w]: PC <= TA_SIMT[w].
  4. Qual3[w]: PC <= TA_ID_IF.
  5. Granted this cycle: PC <= PC + 4 (mod 1024; 10'h3FC wraps to 10'h000).
  6. Otherwise hold.
- Exit_ID_IF[w] clears Active[w]; a Start for the same warp in the same cycle wins (warp ends active). Redirects to an inactive warp still load PC but cause no fetch.
- Eligible[w] = Active[w] & ~Stall_SIMT_IF[w] & ~Full_IB_IF[w] & ~Qual1[w] & ~Qual2[w] & ~Qual3[w] & ~Exit_ID_IF[w] & ~(start targeting w).
- Grant: the first eligible warp scanning Last+1, Last+2, … , Last+8 (mod 8). On grant, Last <= granted warp. If nothing is eligible, Last holds.
- A granted fetch uses the PC value held before this edge; the registered output carries that PC.
- Active_IF = Active register (no combinational bypass).

## Timing
- Reset: every PC = 0, Active = 0, Last = 7 (so warp 0 has first priority), PC_IF_ICache = 0, WarpID_IF_ICache = 0, Valid_IF_ICache = 0.
- A grant decided in cycle t appears on the outputs after edge t+1. Valid is high for exactly one cycle per grant.
- A start in cycle t gives Active = 1 after edge t. The warp is eligible from cycle t+1, so its first fetch is visible after edge t+2.
- A redirect in cycle t blocks that warp's grant in cycle t. The target is fetched no earlier than cycle t+1 (visible after edge t+2).
- Stall or Full in cycle t blocks the grant in cycle t only. These inputs are combinational into arbitration; no internal registering.
- Reset asserted mid-operation clears all state immediately (asynchronous). Any in-flight Valid drops with reset.
- Throughput: up to one fetch per cycle. With N eligible warps held steady, each warp receives one grant every N cycles.

## Configuration
- FETCH_PERF_CNT_EN defined: adds output FetchCnt_IF [15:0], the number of granted fetches since reset. It saturates at 16'hFFFF, resets to 0, and updates on the same edge as Valid_IF_ICache.
- FETCH_PERF_CNT_EN undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Reset, then start warp 0 with PC 0x040 at cycle 1 -> Valid rises after edge 3 with PC 0x040, WarpID 0; the next fetches are 0x044, 0x048 on consecutive cycles.
- Start warps 0, 3, 5 (PCs 0x000/0x100/0x200), no stalls -> grant order 0,3,5,0,3,5 and PCs 0x000,0x100,0x200,0x004,0x104,0x204.
- Warp 3 with Qual1, Qual2 and Qual3 all set together; TA_SIMT[3]=0x120, TA_ID=0x300 -> PC[3] = 0x120 and warp 3 is not granted that cycle. Next, Qual3 only -> PC[3] = 0x300.
- Stall_SIMT_IF = 8'h01, then Full_IB_IF = 8'h20, with warps 0 and 5 active -> no fetch for the blocked warp in those cycles, and the other warp is granted every cycle.
- Warp at PC 0x3FC granted -> emitted PC 0x3FC and PC wraps to 0x000. Exit and Start for warp 2 in the same cycle -> warp 2 stays active at the new StartPC.
- Assert rst mid-stream with 3 warps active -> Valid = 0 and Active_IF = 8'h00 immediately, with no fetch until a new start. With FETCH_PERF_CNT_EN, 10 grants give FetchCnt_IF = 10, and a preload near the limit saturates at 16'hFFFF.
